// File: rtl/router_pkg.sv
// Shared types and constants for the 1-to-3 packet router subsystem.
// Holds the FSM state encoding, port address codes and FIFO geometry.
package router_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int TIMEOUT    = 30;
    localparam int FIFO_W     = DATA_W + 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int TMO_W      = $clog2(TIMEOUT);

    localparam logic [1:0] PORT0   = 2'd0;
    localparam logic [1:0] PORT1   = 2'd1;
    localparam logic [1:0] PORT2   = 2'd2;
    localparam logic [1:0] INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_t;

    // Only the two states that sample datain every cycle let the source advance.
    function automatic logic state_busy(input router_state_t s);
        return !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous FIFO for one router output port; word bit 8 marks a packet header.
// Read data is registered: a popped word is presented for exactly one cycle, else 0x00.
module router_fifo
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              i_resetn,
    input  logic              i_soft_rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [FIFO_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_full
);

    localparam int CNT_W = PTR_W + 1;

    logic [FIFO_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data;
    logic              w_flush;
    logic              w_do_wr;
    logic              w_do_rd;

    assign w_flush = !i_resetn || i_soft_rst;
    assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty = (r_count == CNT_W'(0));
    assign w_do_wr = i_we && !o_full && !w_flush;
    assign w_do_rd = i_re && !o_empty && !w_flush;
    assign o_data  = r_data;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rptr <= r_rptr + PTR_W'(1);
                r_data <= r_mem[r_rptr][DATA_W-1:0];
            end else begin
                r_data <= '0;
            end
            r_count <= r_count + CNT_W'(w_do_wr) - CNT_W'(w_do_rd);
        end
    end

endmodule

// File: rtl/router_top.sv
// 1-to-3 byte-serial packet router: header-addressed steering into three FIFOs with parity check.
// Optional macro SOFT_RESET_TIMEOUT_EN flushes a port whose data sits unread for TIMEOUT cycles.
module router_top
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              packet_valid,
    input  logic [DATA_W-1:0] datain,
    input  logic              read_enb_0,
    input  logic              read_enb_1,
    input  logic              read_enb_2,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2,
    output logic              vld_out_0,
    output logic              vld_out_1,
    output logic              vld_out_2,
    output logic              busy,
    output logic              err
);

    router_state_t     r_state;
    logic [1:0]        r_addr;
    logic [DATA_W-1:0] r_header;
    logic [DATA_W-1:0] r_int_parity;
    logic [DATA_W-1:0] r_rx_parity;
    logic [DATA_W-1:0] r_held;
    logic              r_held_vld;
    logic              r_err;

    logic [2:0]        w_rd;
    logic [2:0]        w_we;
    logic [2:0]        w_full;
    logic [2:0]        w_empty;
    logic [2:0]        w_soft_rst;
    logic [3:0]        w_full4;
    logic [3:0]        w_empty4;
    logic [DATA_W-1:0] w_dout [3];
    logic              w_wr;
    logic [FIFO_W-1:0] w_wdata;
    logic              w_tgt_full;

    // Address 3 never targets a FIFO; padding the vectors keeps every index in range.
    assign w_rd       = {read_enb_2, read_enb_1, read_enb_0};
    assign w_full4    = {1'b1, w_full};
    assign w_empty4   = {1'b0, w_empty};
    assign w_tgt_full = w_full4[r_addr];
    assign w_we       = w_wr ? (3'b001 << r_addr) : 3'b000;

    for (genvar p = 0; p < 3; p++) begin : g_port
        router_fifo u_fifo (
            .clk        (clk),
            .i_resetn   (resetn),
            .i_soft_rst (w_soft_rst[p]),
            .i_we       (w_we[p]),
            .i_re       (w_rd[p]),
            .i_wdata    (w_wdata),
            .o_data     (w_dout[p]),
            .o_empty    (w_empty[p]),
            .o_full     (w_full[p])
        );
    end

    assign data_out_0 = w_dout[0];
    assign data_out_1 = w_dout[1];
    assign data_out_2 = w_dout[2];
    assign vld_out_0  = !w_empty[0];
    assign vld_out_1  = !w_empty[1];
    assign vld_out_2  = !w_empty[2];
    assign busy       = state_busy(r_state);
    assign err        = r_err;

`ifdef SOFT_RESET_TIMEOUT_EN
    for (genvar p = 0; p < 3; p++) begin : g_tmo
        logic [TMO_W-1:0] r_tmo_cnt;
        logic             w_idle;

        assign w_idle        = !w_empty[p] && !w_rd[p];
        assign w_soft_rst[p] = w_idle && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

        // Consecutive unread-while-valid cycles; any read or flush restarts the count.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_tmo_cnt <= '0;
            end else if (!w_idle || w_soft_rst[p]) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
        end
    end
`else
    assign w_soft_rst = 3'b000;
`endif

    // FIFO write strobe and data chosen by the loading state.
    always_comb begin
        w_wr    = 1'b0;
        w_wdata = '0;
        case (r_state)
            LOAD_FIRST_DATA: begin
                w_wr    = 1'b1;
                w_wdata = {1'b1, r_header};
            end
            LOAD_DATA: begin
                if (packet_valid && !w_tgt_full) begin
                    w_wr    = 1'b1;
                    w_wdata = {1'b0, datain};
                end else begin
                    w_wr    = 1'b0;
                end
            end
            LOAD_AFTER_FULL: begin
                w_wr    = r_held_vld;
                w_wdata = {1'b0, r_held};
            end
            LOAD_PARITY: begin
                w_wr    = !w_tgt_full;
                w_wdata = {1'b0, r_rx_parity};
            end
            default: begin
                w_wr    = 1'b0;
                w_wdata = '0;
            end
        endcase
    end

    // Packet FSM with parity accumulation and the registered error flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= DECODE_ADDRESS;
            r_addr       <= PORT0;
            r_header     <= '0;
            r_int_parity <= '0;
            r_rx_parity  <= '0;
            r_held       <= '0;
            r_held_vld   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (packet_valid && (datain[1:0] != INVALID)) begin
                        r_addr       <= datain[1:0];
                        r_header     <= datain;
                        r_int_parity <= datain;
                        r_err        <= 1'b0;
                        r_state      <= w_full4[datain[1:0]] ? WAIT_TILL_EMPTY : LOAD_FIRST_DATA;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (w_empty4[r_addr]) begin
                        r_state <= LOAD_FIRST_DATA;
                    end
                end
                LOAD_FIRST_DATA: begin
                    r_state <= LOAD_DATA;
                end
                // The source treats this byte as taken, so a byte that finds the FIFO full is held.
                LOAD_DATA: begin
                    if (!packet_valid) begin
                        r_rx_parity <= datain;
                        r_state     <= LOAD_PARITY;
                    end else if (w_tgt_full) begin
                        r_held       <= datain;
                        r_held_vld   <= 1'b1;
                        r_int_parity <= r_int_parity ^ datain;
                        r_state      <= FIFO_FULL_STATE;
                    end else begin
                        r_int_parity <= r_int_parity ^ datain;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!w_tgt_full) begin
                        r_state <= LOAD_AFTER_FULL;
                    end
                end
                // Entered from CHECK_PARITY_ERROR with nothing held: the packet is already complete.
                LOAD_AFTER_FULL: begin
                    r_held_vld <= 1'b0;
                    if (!r_held_vld) begin
                        r_state <= DECODE_ADDRESS;
                    end else if (!packet_valid) begin
                        r_rx_parity <= datain;
                        r_state     <= LOAD_PARITY;
                    end else begin
                        r_state <= LOAD_DATA;
                    end
                end
                LOAD_PARITY: begin
                    if (!w_tgt_full) begin
                        r_state <= CHECK_PARITY_ERROR;
                    end
                end
                CHECK_PARITY_ERROR: begin
                    r_err   <= (r_int_parity != r_rx_parity);
                    r_state <= w_tgt_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: begin
                    r_state <= DECODE_ADDRESS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_top.sv
// Self-checking bench for router_top: random packets scored against per-port byte queues.
// The reference model holds each port's expected read stream and each packet's parity verdict.
module tb_router_top;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       packet_valid = 1'b0;
    logic [7:0] datain = 8'h00;
    logic [2:0] rd_sel = 3'b000;
    logic [2:0] rd_force = 3'b000;
    bit         rand_mode = 1'b0;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       busy, err;

    int         n_total = 0;
    int         n_bad = 0;
    logic [7:0] mq [3][$];

    router_top dut (
        .clk          (clk),
        .resetn       (resetn),
        .packet_valid (packet_valid),
        .datain       (datain),
        .read_enb_0   (rd_sel[0]),
        .read_enb_1   (rd_sel[1]),
        .read_enb_2   (rd_sel[2]),
        .data_out_0   (data_out_0),
        .data_out_1   (data_out_1),
        .data_out_2   (data_out_2),
        .vld_out_0    (vld_out_0),
        .vld_out_1    (vld_out_1),
        .vld_out_2    (vld_out_2),
        .busy         (busy),
        .err          (err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dout_of(input int p);
        case (p)
            0: return data_out_0;
            1: return data_out_1;
            default: return data_out_2;
        endcase
    endfunction

    function automatic logic vld_of(input int p);
        case (p)
            0: return vld_out_0;
            1: return vld_out_1;
            default: return vld_out_2;
        endcase
    endfunction

    // Read-enable driver: random per cycle, or a fixed pattern.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_mode) rd_sel = 3'($urandom_range(0, 7));
            else rd_sel = rd_force;
        end
    end

    // Read-stream scoreboard: a read seen at an edge must yield the next expected byte.
    initial begin
        bit hit [3];
        forever begin
            @(posedge clk);
            for (int p = 0; p < 3; p++) hit[p] = resetn && rd_sel[p] && (vld_of(p) === 1'b1);
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (hit[p]) begin
                    if (mq[p].size() == 0) check_val($sformatf("underflow%0d", p), 32'd1, 32'd0);
                    else check_val($sformatf("dout%0d", p), 32'(dout_of(p)), 32'(mq[p].pop_front()));
                end else begin
                    check_val($sformatf("dout_idle%0d", p), 32'(dout_of(p)), 32'd0);
                end
                if (mq[p].size() == 0) check_val($sformatf("vld_empty%0d", p), 32'(vld_of(p)), 32'd0);
            end
        end
    end

    // Present one byte and hold it until an edge where the router is not busy.
    task automatic send_byte(input logic [7:0] b, input logic pv);
        int n = 0;
        packet_valid = pv;
        datain = b;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_val("busy_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_pkt(input int addr, input int len, input bit bad);
        logic [7:0] hdr, b, par;
        hdr = {len[5:0], addr[1:0]};
        par = hdr;
        mq[addr].push_back(hdr);
        send_byte(hdr, 1'b1);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            par = par ^ b;
            mq[addr].push_back(b);
            send_byte(b, 1'b1);
        end
        if (bad) par = par ^ (8'h01 << $urandom_range(0, 7));
        mq[addr].push_back(par);
        send_byte(par, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((mq[0].size() + mq[1].size() + mq[2].size()) != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", 32'(mq[0].size() + mq[1].size() + mq[2].size()), 32'd0);
        check_val("drained_vld", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'd0);
    endtask

    initial begin
        int a, l;
        bit bad;

        // Reset state
        repeat (2) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            check_val("rst_dout", 32'(dout_of(p)), 32'd0);
            check_val("rst_vld", 32'(vld_of(p)), 32'd0);
        end
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Streamed packet on port 0 with reads enabled
        rd_force = 3'b111;
        send_pkt(0, 8, 1'b0);
        wait_idle();
        check_val("err_p0", 32'(err), 32'd0);
        wait_drain();

        // Ports 1 and 2: only the addressed port shows data
        for (int p = 1; p < 3; p++) begin
            rd_force = 3'b000;
            send_pkt(p, 8, 1'b0);
            wait_idle();
            for (int q = 0; q < 3; q++)
                check_val($sformatf("addr_vld%0d_%0d", p, q), 32'(vld_of(q)), (q == p) ? 32'd1 : 32'd0);
            rd_force = 3'b111;
            wait_drain();
        end

        // Wrong parity: err rises two cycles after the parity byte, holds, then clears
        send_pkt(0, 8, 1'b1);
        @(negedge clk);
        check_val("err_t1", 32'(err), 32'd0);
        @(negedge clk);
        check_val("err_t2", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        check_val("err_hold", 32'(err), 32'd1);
        send_pkt(1, 4, 1'b0);
        wait_idle();
        check_val("err_clear", 32'(err), 32'd0);
        wait_drain();

        // FIFO fill with port 0 unread: busy holds until reads drain it
        rd_force = 3'b000;
        send_pkt(0, 5, 1'b0);
        send_pkt(0, 5, 1'b0);
        check_val("fill_vld", 32'(vld_out_0), 32'd1);
        fork
            send_pkt(0, 5, 1'b0);
            begin
                repeat (30) @(negedge clk);
                check_val("fill_busy", 32'(busy), 32'd1);
                check_val("fill_full_vld", 32'(vld_out_0), 32'd1);
                rd_force = 3'b001;
            end
        join
        wait_idle();
        check_val("fill_err", 32'(err), 32'd0);
        rd_force = 3'b111;
        wait_drain();

        // Random traffic with random read enables
        rand_mode = 1'b1;
        for (int k = 0; k < 25; k++) begin
            a = $urandom_range(0, 2);
            l = $urandom_range(0, 15);
            bad = ($urandom_range(0, 3) == 0);
            send_pkt(a, l, bad);
            wait_idle();
            check_val($sformatf("err_rand%0d", k), 32'(err), 32'(bad));
        end
        rand_mode = 1'b0;
        rd_force = 3'b111;
        wait_drain();

        // Reset with all ports holding a packet, then an invalid-address header
        rd_force = 3'b000;
        for (int p = 0; p < 3; p++) send_pkt(p, 3, 1'b0);
        wait_idle();
        for (int p = 0; p < 3; p++) check_val($sformatf("pre_rst_vld%0d", p), 32'(vld_of(p)), 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        for (int p = 0; p < 3; p++) mq[p].delete();
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            check_val($sformatf("mid_rst_dout%0d", p), 32'(dout_of(p)), 32'd0);
            check_val($sformatf("mid_rst_vld%0d", p), 32'(vld_of(p)), 32'd0);
        end
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        send_byte(8'h23, 1'b1);
        packet_valid = 1'b0;
        datain = 8'h00;
        repeat (5) @(negedge clk);
        for (int p = 0; p < 3; p++) check_val($sformatf("inv_vld%0d", p), 32'(vld_of(p)), 32'd0);
        check_val("inv_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
